// File: rtl/comparator_1_bit_behavioral_pkg.sv
// comparator_pkg: shared types and constants for the registered comparator.
//   cmp_result_t  - 3-bit one-hot compare result {lt, gt, eq}
//   CMP_RESET_VAL - idle/reset result (equal)
//   STATS_W       - width of the optional statistics counters
//   sat_inc       - saturating increment for the statistics counters
package comparator_pkg;

  typedef enum logic [2:0] {
    CMP_EQ = 3'b001,
    CMP_GT = 3'b010,
    CMP_LT = 3'b100
  } cmp_result_t;

  localparam cmp_result_t CMP_RESET_VAL = CMP_EQ;

  localparam int unsigned STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/comparator_1_bit_behavioral_if.sv
// comparator_1_bit_behavioral_if: operand/result bundle for the comparator.
//   in_valid, a, b                        - driven by the requester (master)
//   out_valid, a_equals_b, a_greater_b,
//   a_less_b                              - driven by the comparator (slave)
interface comparator_1_bit_behavioral_if #(
  parameter int unsigned WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             a_equals_b;
  logic             a_greater_b;
  logic             a_less_b;

  modport master (
    output in_valid, a, b,
    input  out_valid, a_equals_b, a_greater_b, a_less_b
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, a_equals_b, a_greater_b, a_less_b
  );

endinterface

// File: rtl/comparator_1_bit_behavioral_cmp_core.sv
// cmp_core: combinational magnitude compare of a against b.
//   a, b   - operands (WIDTH bits)
//   result - one-hot cmp_result_t; SIGNED_CMP=1 treats the MSB as sign
module cmp_core
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_result_t      result
);

  always_comb begin
    result = CMP_EQ;
    if (SIGNED_CMP) begin
      if ($signed(a) > $signed(b))      result = CMP_GT;
      else if ($signed(a) < $signed(b)) result = CMP_LT;
    end else begin
      if (a > b)      result = CMP_GT;
      else if (a < b) result = CMP_LT;
    end
  end

endmodule

// File: rtl/comparator_1_bit_behavioral.sv
// comparator_1_bit_behavioral: registered magnitude comparator, 1-cycle latency.
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   bus      - comparator_1_bit_behavioral_if.slave (operands in, flags out)
// Optional statistics (macro COMPARATOR_STATS_EN):
//   stats_clear                   - synchronous clear of all counters
//   eq_count, gt_count, lt_count  - saturating per-result counters
module comparator_1_bit_behavioral
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  comparator_1_bit_behavioral_if.slave bus
`ifdef COMPARATOR_STATS_EN
  ,
  input  logic                         stats_clear,
  output logic [STATS_W-1:0]           eq_count,
  output logic [STATS_W-1:0]           gt_count,
  output logic [STATS_W-1:0]           lt_count
`endif
);

  cmp_result_t cmp_res;
  cmp_result_t flags_d, flags_q;
  logic        valid_d, valid_q;

  cmp_core #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp_core (
    .a      (bus.a),
    .b      (bus.b),
    .result (cmp_res)
  );

  // Flags hold when no operand is accepted; the mux select keeps X on
  // idle operands away from the registers.
  always_comb begin
    valid_d = bus.in_valid;
    flags_d = flags_q;
    if (bus.in_valid) flags_d = cmp_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      flags_q <= CMP_RESET_VAL;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.a_equals_b  = flags_q[0];
  assign bus.a_greater_b = flags_q[1];
  assign bus.a_less_b    = flags_q[2];

`ifdef COMPARATOR_STATS_EN
  logic [STATS_W-1:0] eq_count_d, eq_count_q;
  logic [STATS_W-1:0] gt_count_d, gt_count_q;
  logic [STATS_W-1:0] lt_count_d, lt_count_q;

  always_comb begin
    eq_count_d = eq_count_q;
    gt_count_d = gt_count_q;
    lt_count_d = lt_count_q;
    if (stats_clear) begin
      eq_count_d = '0;
      gt_count_d = '0;
      lt_count_d = '0;
    end else if (bus.in_valid) begin
      if (cmp_res == CMP_EQ) eq_count_d = sat_inc(eq_count_q);
      if (cmp_res == CMP_GT) gt_count_d = sat_inc(gt_count_q);
      if (cmp_res == CMP_LT) lt_count_d = sat_inc(lt_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_count_q <= '0;
      gt_count_q <= '0;
      lt_count_q <= '0;
    end else begin
      eq_count_q <= eq_count_d;
      gt_count_q <= gt_count_d;
      lt_count_q <= lt_count_d;
    end
  end

  assign eq_count = eq_count_q;
  assign gt_count = gt_count_q;
  assign lt_count = lt_count_q;
`endif

endmodule

// File: tb/tb_comparator_1_bit_behavioral.sv
// Bench for comparator_1_bit_behavioral: four instances (1-bit unsigned,
// 1-bit signed, 8-bit unsigned, 8-bit signed) driven with the same vectors;
// 1-bit instances see bit 0 of each operand.
module tb_comparator_1_bit_behavioral;
  import comparator_pkg::*;

  // {out_valid, lt, gt, eq}
  localparam logic [3:0] E  = 4'b1001;
  localparam logic [3:0] G  = 4'b1010;
  localparam logic [3:0] L  = 4'b1100;
  localparam logic [3:0] HG = 4'b0010;
  localparam logic [3:0] HL = 4'b0100;
  localparam logic [3:0] RST = 4'b0001;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [3:0] e_u1;
    logic [3:0] e_s1;
    logic [3:0] e_u8;
    logic [3:0] e_s8;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  comparator_1_bit_behavioral_if #(.WIDTH(1)) if_u1 ();
  comparator_1_bit_behavioral_if #(.WIDTH(1)) if_s1 ();
  comparator_1_bit_behavioral_if #(.WIDTH(8)) if_u8 ();
  comparator_1_bit_behavioral_if #(.WIDTH(8)) if_s8 ();

`ifdef COMPARATOR_STATS_EN
  logic        stats_clear;
  logic [15:0] eq_cnt [4];
  logic [15:0] gt_cnt [4];
  logic [15:0] lt_cnt [4];
`endif

  comparator_1_bit_behavioral #(.WIDTH(1), .SIGNED_CMP(1'b0)) u_u1 (
    .clk(clk), .rst(rst), .bus(if_u1.slave)
`ifdef COMPARATOR_STATS_EN
    , .stats_clear(stats_clear), .eq_count(eq_cnt[0]), .gt_count(gt_cnt[0]), .lt_count(lt_cnt[0])
`endif
  );

  comparator_1_bit_behavioral #(.WIDTH(1), .SIGNED_CMP(1'b1)) u_s1 (
    .clk(clk), .rst(rst), .bus(if_s1.slave)
`ifdef COMPARATOR_STATS_EN
    , .stats_clear(stats_clear), .eq_count(eq_cnt[1]), .gt_count(gt_cnt[1]), .lt_count(lt_cnt[1])
`endif
  );

  comparator_1_bit_behavioral #(.WIDTH(8), .SIGNED_CMP(1'b0)) u_u8 (
    .clk(clk), .rst(rst), .bus(if_u8.slave)
`ifdef COMPARATOR_STATS_EN
    , .stats_clear(stats_clear), .eq_count(eq_cnt[2]), .gt_count(gt_cnt[2]), .lt_count(lt_cnt[2])
`endif
  );

  comparator_1_bit_behavioral #(.WIDTH(8), .SIGNED_CMP(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .bus(if_s8.slave)
`ifdef COMPARATOR_STATS_EN
    , .stats_clear(stats_clear), .eq_count(eq_cnt[3]), .gt_count(gt_cnt[3]), .lt_count(lt_cnt[3])
`endif
  );

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
    if_u1.a = a[0]; if_u1.b = b[0]; if_u1.in_valid = v;
    if_s1.a = a[0]; if_s1.b = b[0]; if_s1.in_valid = v;
    if_u8.a = a;    if_u8.b = b;    if_u8.in_valid = v;
    if_s8.a = a;    if_s8.b = b;    if_s8.in_valid = v;
  endtask

  function automatic logic [3:0] st_u1();
    return {if_u1.out_valid, if_u1.a_less_b, if_u1.a_greater_b, if_u1.a_equals_b};
  endfunction
  function automatic logic [3:0] st_s1();
    return {if_s1.out_valid, if_s1.a_less_b, if_s1.a_greater_b, if_s1.a_equals_b};
  endfunction
  function automatic logic [3:0] st_u8();
    return {if_u8.out_valid, if_u8.a_less_b, if_u8.a_greater_b, if_u8.a_equals_b};
  endfunction
  function automatic logic [3:0] st_s8();
    return {if_s8.out_valid, if_s8.a_less_b, if_s8.a_greater_b, if_s8.a_equals_b};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs [12];

  initial begin
    // a, b, valid, u1, s1, u8, s8
    vecs[0]  = '{8'h00, 8'h00, 1'b1, E,  E,  E,  E };
    vecs[1]  = '{8'h00, 8'h01, 1'b1, L,  G,  L,  L };
    vecs[2]  = '{8'h01, 8'h00, 1'b1, G,  L,  G,  G };
    vecs[3]  = '{8'h01, 8'h01, 1'b1, E,  E,  E,  E };
    vecs[4]  = '{8'h80, 8'h7F, 1'b1, L,  G,  G,  L };
    vecs[5]  = '{8'h7F, 8'h80, 1'b1, G,  L,  L,  G };
    vecs[6]  = '{8'h01, 8'h00, 1'b1, G,  L,  G,  G };
    vecs[7]  = '{8'h00, 8'h01, 1'b0, HG, HL, HG, HG};
    vecs[8]  = '{8'hxx, 8'hxx, 1'b0, HG, HL, HG, HG};
    vecs[9]  = '{8'hFF, 8'hFE, 1'b1, G,  L,  G,  G };
    vecs[10] = '{8'hFE, 8'hFF, 1'b1, L,  G,  L,  L };
    vecs[11] = '{8'h80, 8'h80, 1'b1, E,  E,  E,  E };

`ifdef COMPARATOR_STATS_EN
    stats_clear = 1'b0;
`endif
    // Reset is visible before any clock edge, with a valid GT pair applied.
    rst = 1'b1;
    drive(8'h01, 8'h00, 1'b1);
    #1;
    check("reset_u1", 16'(st_u1()), 16'(RST));
    check("reset_s1", 16'(st_s1()), 16'(RST));
    check("reset_u8", 16'(st_u8()), 16'(RST));
    check("reset_s8", 16'(st_s8()), 16'(RST));

    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].v);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_u1", i), 16'(st_u1()), 16'(vecs[i].e_u1));
      check($sformatf("vec%0d_s1", i), 16'(st_s1()), 16'(vecs[i].e_s1));
      check($sformatf("vec%0d_u8", i), 16'(st_u8()), 16'(vecs[i].e_u8));
      check($sformatf("vec%0d_s8", i), 16'(st_s8()), 16'(vecs[i].e_s8));
    end

    // Mid-stream reset: pending LT result is discarded, reset is immediate.
    @(negedge clk);
    drive(8'h01, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_u1", 16'(st_u1()), 16'(G));
    @(negedge clk);
    drive(8'h00, 8'h01, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_async_u1", 16'(st_u1()), 16'(RST));
    check("mid_rst_async_s8", 16'(st_s8()), 16'(RST));
    @(posedge clk);
    #1;
    check("mid_rst_hold_u1", 16'(st_u1()), 16'(RST));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_u1", 16'(st_u1()), 16'(L));
    check("post_rst_s1", 16'(st_s1()), 16'(G));

`ifdef COMPARATOR_STATS_EN
    // Clear coincides with a valid compare: clear wins.
    @(negedge clk);
    stats_clear = 1'b1;
    drive(8'h01, 8'h01, 1'b1);
    @(posedge clk);
    #1;
    check("clr0_eq", eq_cnt[0], 16'd0);
    check("clr0_gt", gt_cnt[0], 16'd0);
    check("clr0_lt", lt_cnt[0], 16'd0);
    @(negedge clk);
    stats_clear = 1'b0;
    drive(8'h00, 8'h00, 1'b1);
    @(negedge clk); drive(8'h01, 8'h01, 1'b1);
    @(negedge clk); drive(8'h00, 8'h00, 1'b1);
    @(negedge clk); drive(8'h01, 8'h00, 1'b1);
    @(negedge clk); drive(8'h01, 8'h00, 1'b1);
    @(negedge clk); drive(8'h00, 8'h01, 1'b1);
    @(negedge clk); drive(8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("cnt_eq", eq_cnt[0], 16'd3);
    check("cnt_gt", gt_cnt[0], 16'd2);
    check("cnt_lt", lt_cnt[0], 16'd1);
    @(negedge clk);
    stats_clear = 1'b1;
    drive(8'h01, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check("clr1_eq", eq_cnt[0], 16'd0);
    check("clr1_gt", gt_cnt[0], 16'd0);
    check("clr1_lt", lt_cnt[0], 16'd0);
    @(negedge clk);
    stats_clear = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_1_bit_behavioral.md
Name: comparator_1_bit_behavioral

Overview:
- Registered magnitude comparator. Compares operand a against operand b and produces three mutually exclusive one-hot flags: equal, greater, less.
- Default build is the 1-bit compare used in control paths. WIDTH scales it for datapath compares.
- Leaf block, instantiated wherever a clean registered compare result is needed.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).
- SIGNED_CMP, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a and b are sampled on this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result flags refer to the last accepted operand pair, updated this cycle.
- a_equals_b  output  1  high when A == B.
- a_greater_b  output  1  high when A > B.
- a_less_b  output  1  high when A < B.

Behaviour:
- Reset (asynchronous assert, synchronous-release usage assumed by system):
  - out_valid = 0, a_equals_b = 1, a_greater_b = 0, a_less_b = 0.
  - The equal flag is the defined idle state.
- Latency is exactly 1 cycle. in_valid = 1 at edge N gives out_valid = 1 and updated flags after edge N.
- in_valid = 0 at an edge:
  - out_valid drops to 0.
  - The flags hold their previous values; they are not cleared.
- Flags are always exactly one-hot, including after reset. Any other state is a design error.
- Unsigned mode: plain magnitude compare.
  - WIDTH=1: a=1,b=0 gives greater; a=0,b=1 gives less.
- Signed mode: the MSB is the sign.
  - WIDTH=1: bit value 1 means -1, so a=1,b=0 gives less.
- No internal state other than the output registers. Back-to-back in_valid every cycle is fully supported, giving one result per cycle.
- Reset asserted mid-stream: outputs go immediately to reset values. The pending result is discarded.
- X on a or b while in_valid = 0 must not propagate to the flags.

Optional Feature:
- Macro: COMPARATOR_STATS_EN.
- Defined:
  - Adds input stats_clear (1 bit).
  - Adds outputs eq_count, gt_count, lt_count (each 16 bits).
  - Each counter increments on the cycle its flag is registered with in_valid = 1.
  - Counters saturate at 16'hFFFF.
  - Counters clear on rst or on synchronous stats_clear. If stats_clear and an increment coincide, the clear wins.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package comparator_pkg holds:
  - typedef cmp_result_t: 3-bit one-hot, with constants CMP_EQ = 3'b001, CMP_GT = 3'b010, CMP_LT = 3'b100.
  - constant CMP_RESET_VAL = CMP_EQ.
  - constant STATS_W = 16.
- One natural combinational sub-module, cmp_core, maps (a, b, signed mode) to cmp_result_t.
- The top level holds the registers, valid tracking and optional statistics.

Test Plan:
- Reset: assert rst with a=1,b=0,in_valid=1 -> out_valid=0, eq=1, gt=0, lt=0 immediately, with no clock edge needed.
- WIDTH=1 unsigned exhaustive: pairs (0,0),(0,1),(1,0),(1,1) applied one per cycle with in_valid=1 -> one cycle later the flags are EQ, LT, GT, EQ respectively and out_valid=1 throughout.
- Valid gap: apply (1,0) with valid, then in_valid=0 with a=0,b=1 -> out_valid=0 and the flags stay GT.
- SIGNED_CMP=1, WIDTH=1: apply (1,0) -> LT; apply (0,1) -> GT.
- WIDTH=8, SIGNED_CMP=1: apply (8'h80, 8'h7F) -> LT; with SIGNED_CMP=0 the same pair -> GT.
- COMPARATOR_STATS_EN: apply 3 EQ, 2 GT and 1 LT compares -> counters read 3/2/1. Pulse stats_clear together with a valid compare -> all counters read 0.
